// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
//   Shared definitions for the audio recorder slice:
//     state_t              recorder FSM states
//     CLK_HZ_DEFAULT       default system clock frequency (Hz)
//     SAMPLE_RATE_DEFAULT  default audio sample rate (Hz)
//     therm16()            level 0..16 -> 16-bit thermometer code
// ----------------------------------------------------------------------------
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    localparam int CLK_HZ_DEFAULT      = 50_000_000;
    localparam int SAMPLE_RATE_DEFAULT = 48_000;

    // Level n lights the n lowest LEDs; levels above 16 saturate.
    function automatic logic [15:0] therm16(input logic [4:0] n);
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < n) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/audio_frame_ram.sv
// ----------------------------------------------------------------------------
// audio_frame_ram
//   Single-port synchronous RAM holding DEPTH audio frames of WIDTH bits.
//   One-cycle read latency; written in a form block-RAM inference accepts.
//   Ports:
//     clk    system clock
//     we     write enable (writes wdata to addr)
//     addr   frame address
//     wdata  frame to write
//     rdata  frame at addr, registered (valid the cycle after the access)
// ----------------------------------------------------------------------------
module audio_frame_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; a reset term would stop it mapping onto
    // block RAM, and recorded audio is meant to survive a reset anyway.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/key_edge.sv
// ----------------------------------------------------------------------------
// key_edge
//   Synchronises an asynchronous active-low pushbutton into the clk domain
//   and emits a one-cycle pulse on each press (1->0 of the synchronised key).
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset (flops reset to the released level)
//     key    raw active-low pushbutton
//     press  one-cycle press pulse
// ----------------------------------------------------------------------------
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    // [0],[1]: two-flop synchroniser; [2]: previous synchronised value.
    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], key};
        end
    end

    assign press = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/audio_recorder.sv
// ----------------------------------------------------------------------------
// audio_recorder
//   Records live audio frames into an on-chip buffer at the sample rate and
//   plays them back on request.
//   Ports:
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     mic_in     live frame, channel 0 in the LSBs
//     rec_key    active-low record/stop button (asynchronous)
//     play_key   active-low play/abort button (asynchronous)
//     audio_out  playback frame in PLAY, else registered mic_in
//     ledr       [15:0] progress bar, [16] recording, [17] playing
//     busy       high while recording or playing
//     rec_len    frames held from the last recording
// ----------------------------------------------------------------------------
module audio_recorder
    import audio_pkg::*;
#(
    parameter  int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter  int SAMPLE_RATE = SAMPLE_RATE_DEFAULT,
    parameter  int CHANNELS    = 2,
    parameter  int SAMPLE_W    = 16,
    parameter  int DEPTH       = 96000,
    localparam int FW          = CHANNELS * SAMPLE_W,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [FW-1:0] mic_in,
    input  logic          rec_key,
    input  logic          play_key,
    output logic [FW-1:0] audio_out,
    output logic [17:0]   ledr,
    output logic          busy,
    output logic [AW:0]   rec_len
);

    localparam int DIV = CLK_HZ / SAMPLE_RATE;
    localparam int CW  = $clog2(DIV);

    state_t          state;
    logic [AW:0]     addr;       // reaches DEPTH / rec_len, hence one extra bit
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic            rec_press;
    logic            play_press;
    logic            ram_we;
    logic [FW-1:0]   ram_rdata;
    logic            rd_pending; // RAM data for the last PLAY tick is ready
    logic            rec_led;
    logic            play_led;
    logic [15:0]     progress_q;

    key_edge u_rec_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (rec_key),
        .press (rec_press)
    );

    key_edge u_play_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (play_key),
        .press (play_press)
    );

    assign tick = (state != ST_IDLE) && (tick_cnt == CW'(DIV - 1));

    // A stop press landing on a tick cancels that tick's write.
    assign ram_we = (state == ST_RECORD) && tick && !rec_press;

    audio_frame_ram #(
        .DEPTH (DEPTH),
        .WIDTH (FW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr[AW-1:0]),
        .wdata (mic_in),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Control FSM with registered status outputs.
    // PLAY ends on the tick after the last frame was fetched, so the final
    // frame is held for a full sample period like every other frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr       <= '0;
            tick_cnt   <= '0;
            rec_len    <= '0;
            busy       <= 1'b0;
            rec_led    <= 1'b0;
            play_led   <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= 1'b0;
            tick_cnt   <= (state == ST_IDLE || tick) ? '0 : tick_cnt + 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (rec_press) begin
                        state    <= ST_RECORD;
                        addr     <= '0;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                        rec_led  <= 1'b1;
                    end else if (play_press && rec_len != '0) begin
                        state    <= ST_PLAY;
                        addr     <= '0;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                        play_led <= 1'b1;
                    end
                end

                ST_RECORD: begin
                    if (rec_press) begin
                        state   <= ST_IDLE;
                        rec_len <= addr;
                        busy    <= 1'b0;
                        rec_led <= 1'b0;
                    end else if (tick) begin
                        addr <= addr + 1'b1;
                        if (addr == (AW+1)'(DEPTH - 1)) begin
                            state   <= ST_IDLE;
                            rec_len <= (AW+1)'(DEPTH);
                            busy    <= 1'b0;
                            rec_led <= 1'b0;
                        end
                    end
                end

                ST_PLAY: begin
                    if (play_press) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        play_led <= 1'b0;
                    end else if (tick) begin
                        if (addr == rec_len) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            play_led <= 1'b0;
                        end else begin
                            addr       <= addr + 1'b1;
                            rd_pending <= 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output frame: fetched RAM data during PLAY, otherwise live input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out <= '0;
        end else if (state == ST_PLAY) begin
            if (rd_pending) audio_out <= ram_rdata;
        end else begin
            audio_out <= mic_in;
        end
    end

    // ------------------------------------------------------------------
    // Progress bar. RECORD divides by the constant DEPTH; PLAY divides by
    // the run-time rec_len, done as 16 compares: LED k-1 lights when
    // addr*16 >= k*rec_len, which is the thermometer of addr*16/rec_len.
    // ------------------------------------------------------------------
    logic [AW+4:0] addr_x16;
    logic [4:0]    rec_level;
    logic [15:0]   play_therm;
    logic [15:0]   progress_d;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        addr_x16   = {addr, 4'b0000};
        rec_level  = 5'(addr_x16 / (AW+5)'(DEPTH));
        play_therm = '0;
        progress_d = '0;
        for (int k = 1; k <= 16; k++) begin
            play_therm[k-1] = addr_x16 >= ((AW+5)'(k) * (AW+5)'(rec_len));
        end
        unique case (state)
            ST_RECORD: progress_d = therm16(rec_level);
            ST_PLAY:   progress_d = play_therm;
            default:   progress_d = (rec_len == (AW+1)'(DEPTH)) ? 16'hFFFF : 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) progress_q <= '0;
        else        progress_q <= progress_d;
    end

    assign ledr = {play_led, rec_led, progress_q};

endmodule

// File: tb/tb_audio_recorder.sv
// ----------------------------------------------------------------------------
// tb_audio_recorder
//   Directed bench for audio_recorder with CLK_HZ=1000, SAMPLE_RATE=100
//   (DIV=10), CHANNELS=2, SAMPLE_W=8, DEPTH=8. Inputs change and outputs are
//   sampled on the falling edge. A key pressed at falling edge N acts on the
//   third rising edge after it (two synchroniser flops plus edge detect).
// ----------------------------------------------------------------------------
module tb_audio_recorder;

    localparam int CLK_HZ      = 1000;
    localparam int SAMPLE_RATE = 100;
    localparam int CHANNELS    = 2;
    localparam int SAMPLE_W    = 8;
    localparam int DEPTH       = 8;
    localparam int FW          = CHANNELS * SAMPLE_W;
    localparam int AW          = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [FW-1:0] mic_in;
    logic          rec_key;
    logic          play_key;
    logic [FW-1:0] audio_out;
    logic [17:0]   ledr;
    logic          busy;
    logic [AW:0]   rec_len;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    audio_recorder #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_RATE (SAMPLE_RATE),
        .CHANNELS    (CHANNELS),
        .SAMPLE_W    (SAMPLE_W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mic_in    (mic_in),
        .rec_key   (rec_key),
        .play_key  (play_key),
        .audio_out (audio_out),
        .ledr      (ledr),
        .busy      (busy),
        .rec_len   (rec_len)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Ramp frames 0x0100, 0x0302, 0x0504, ...
    function automatic logic [15:0] ramp(input int k);
        return {8'(2 * k + 1), 8'(2 * k)};
    endfunction

    function automatic logic [15:0] alt(input int k);
        return {8'(8'hC0 + k), 8'(8'h40 + k)};
    endfunction

    // Called on a falling edge; holds the key low for two cycles and
    // returns two falling edges later.
    task automatic press(input bit is_rec);
        if (is_rec) rec_key = 1'b0;
        else        play_key = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rec_key  = 1'b1;
        play_key = 1'b1;
    endtask

    // Polls each falling edge until busy reaches val, bounded.
    task automatic wait_busy(input logic val, input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === val) break;
        end
        check(tag, {31'd0, busy}, {31'd0, val});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_busy;

        rst_n    = 1'b0;
        rec_key  = 1'b1;
        play_key = 1'b1;
        mic_in   = '0;

        // ---------------- reset and idle pass-through ----------------
        #3;
        check("rst_audio_out", 32'(audio_out), 32'h0);
        check("rst_ledr", 32'(ledr), 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_rec_len", 32'(rec_len), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            logic [15:0] v;
            v = 16'(i * 16'h0123 + 16'h0011);
            mic_in = v;
            @(negedge clk);
            if (i % 10 == 7) check("idle_passthru", 32'(audio_out), 32'(v));
        end
        check("idle_ledr", 32'(ledr), 32'h0);
        check("idle_busy", {31'd0, busy}, 32'h0);
        check("idle_rec_len", 32'(rec_len), 32'h0);

        // ---------------- full 8-frame recording ----------------
        press(1'b1);
        wait_busy(1'b1, "rec_start");
        for (int k = 0; k < 8; k++) begin
            mic_in = ramp(k);
            repeat (5) @(negedge clk);
            if (k == 3) check("rec_progress", 32'(ledr), 32'h1003F);
            repeat (5) @(negedge clk);
        end
        check("rec_full_busy", {31'd0, busy}, 32'h0);
        check("rec_full_len", 32'(rec_len), 32'd8);
        repeat (2) @(negedge clk);
        check("rec_full_ledr", 32'(ledr), 32'h0FFFF);

        // ---------------- full playback ----------------
        mic_in = 16'hAAAA;
        press(1'b0);
        wait_busy(1'b1, "play_start");
        repeat (10) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            repeat (5) @(negedge clk);
            check("play_frame", 32'(audio_out), 32'(ramp(k)));
            if (k == 3) check("play_ledr", 32'(ledr), 32'h200FF);
            repeat (5) @(negedge clk);
        end
        check("play_end_busy", {31'd0, busy}, 32'h0);
        @(negedge clk);
        check("play_end_passthru", 32'(audio_out), 32'hAAAA);

        // ---------------- reset during playback frame 4 ----------------
        press(1'b0);
        wait_busy(1'b1, "play2_start");
        repeat (55) @(negedge clk);
        check("play2_frame4", 32'(audio_out), 32'(ramp(4)));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_audio_out", 32'(audio_out), 32'h0);
        check("midrst_ledr", 32'(ledr), 32'h0);
        check("midrst_busy", {31'd0, busy}, 32'h0);
        check("midrst_rec_len", 32'(rec_len), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_rec_len", 32'(rec_len), 32'h0);
        check("postrst_busy", {31'd0, busy}, 32'h0);

        // ---------------- play with nothing recorded ----------------
        press(1'b0);
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("play_empty_ignored", {31'd0, saw_busy}, 32'h0);
        check("play_empty_ledr", 32'(ledr), 32'h0);

        // ---------------- zero-length recording ----------------
        press(1'b1);
        wait_busy(1'b1, "rec0_start");
        press(1'b1);
        wait_busy(1'b0, "rec0_stop");
        check("rec0_len", 32'(rec_len), 32'h0);

        // ---------------- stop press coincident with third tick ----------------
        mic_in = 16'h1234;
        press(1'b1);
        wait_busy(1'b1, "coin_start");
        mic_in = 16'hD00D;
        repeat (10) @(negedge clk);
        mic_in = 16'hBEEF;
        repeat (10) @(negedge clk);
        mic_in = 16'hCAFE;
        repeat (7) @(negedge clk);
        press(1'b1);
        wait_busy(1'b0, "coin_stop");
        check("coin_len", 32'(rec_len), 32'd2);
        mic_in = 16'h5555;
        press(1'b0);
        wait_busy(1'b1, "coin_play_start");
        repeat (15) @(negedge clk);
        check("coin_play_f0", 32'(audio_out), 32'hD00D);
        repeat (10) @(negedge clk);
        check("coin_play_f1", 32'(audio_out), 32'hBEEF);
        repeat (5) @(negedge clk);
        check("coin_play_end", {31'd0, busy}, 32'h0);
        @(negedge clk);
        check("coin_play_passthru", 32'(audio_out), 32'h5555);

        // ---------------- early stop after 3 frames ----------------
        press(1'b1);
        wait_busy(1'b1, "rec3_start");
        for (int k = 0; k < 3; k++) begin
            mic_in = alt(k);
            repeat (10) @(negedge clk);
        end
        press(1'b1);
        wait_busy(1'b0, "rec3_stop");
        check("rec3_len", 32'(rec_len), 32'd3);
        repeat (2) @(negedge clk);
        check("rec3_ledr", 32'(ledr), 32'h0);
        mic_in = 16'h7777;
        press(1'b0);
        wait_busy(1'b1, "play3_start");
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            repeat (10) @(negedge clk);
            check("play3_frame", 32'(audio_out), 32'(alt(k)));
        end
        repeat (5) @(negedge clk);
        check("play3_end", {31'd0, busy}, 32'h0);
        @(negedge clk);
        check("play3_passthru", 32'(audio_out), 32'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
